dm_sba_v2: RTL

DM_SBA_V2 -- requirements
Module: dm_sba_v2

---
 rtl/dm_sba_v2.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dm_sba_v2.sv
// System bus access master for the debug module: turns sbaddress/sbdata commands into
// single bus transfers with size/alignment checks, autoincrement and a watchdog timeout.
//   state        | meaning
//   S_IDLE       | no transfer, accepting commands
//   S_READ       | read request on bus, waiting for grant
//   S_WRITE      | write request on bus, waiting for grant
//   S_WAIT_READ  | granted read, waiting for r_valid
//   S_WAIT_WRITE | granted write, waiting for r_valid
module dm_sba_v2 #(
    parameter int BusWidth      = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    output logic                  master_req_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbreadondata_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbdata_write_valid_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic                  sbaddress_upd_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sbbusyerror_o,
    output logic                  sberror_valid_o,
    output logic [2:0]            sberror_o
);

    localparam int NumBytes = BusWidth / 8;
    localparam int OffW     = $clog2(NumBytes);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_WAIT_READ,
        S_WAIT_WRITE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [BusWidth-1:0] r_addr, r_wdata, r_sbdata, r_sbaddress;
    logic [2:0]          r_size;
    logic                r_autoinc;
    logic [15:0]         r_cnt;
    logic                r_data_valid, r_addr_upd, r_busyerr, r_err_valid;
    logic [2:0]          r_err;

    logic                w_trig_wr, w_trig_rd, w_trig, w_start, w_busy_hit;
    logic                w_size_err, w_misalign, w_cnt_hit;
    logic [2:0]          w_align_mask;
    logic                w_timeout, w_done, w_done_rd;
    logic [OffW-1:0]     w_off;
    logic [OffW+2:0]     w_shamt;
    int                  w_nbytes;
    logic [NumBytes-1:0] w_be;
    logic [BusWidth-1:0] w_rshift, w_rdata, w_addr_inc;

    always_comb begin
        w_trig_wr    = dmactive_i & sbdata_write_valid_i;
        w_trig_rd    = dmactive_i & ((sbaddress_write_valid_i & sbreadonaddr_i) |
                                     (sbdata_read_valid_i & sbreadondata_i));
        w_trig       = (r_state == S_IDLE) & (w_trig_wr | w_trig_rd);
        w_size_err   = (sbaccess_i > 3'(OffW));
        w_align_mask = (3'b001 << sbaccess_i) - 3'b001;
        w_misalign   = |(sbaddress_i[2:0] & w_align_mask);
        w_start      = w_trig & ~w_size_err & ~w_misalign;
        w_busy_hit   = dmactive_i & (r_state != S_IDLE) &
                       (sbaddress_write_valid_i | sbdata_read_valid_i | sbdata_write_valid_i);
        w_cnt_hit    = (r_cnt == 16'(TimeoutCycles - 1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Timeout takes priority over a grant or response arriving in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        master_req_o = 1'b0;
        master_we_o  = 1'b0;
        w_timeout    = 1'b0;
        w_done       = 1'b0;
        w_done_rd    = 1'b0;
        if (!dmactive_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) w_state_nxt = w_trig_wr ? S_WRITE : S_READ;
                end
                S_READ, S_WRITE: begin
                    master_req_o = 1'b1;
                    master_we_o  = (r_state == S_WRITE);
                    if (w_cnt_hit) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (master_gnt_i) begin
                        w_state_nxt = (r_state == S_WRITE) ? S_WAIT_WRITE : S_WAIT_READ;
                    end
                end
                S_WAIT_READ, S_WAIT_WRITE: begin
                    if (w_cnt_hit) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (master_r_valid_i) begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                        w_done_rd   = (r_state == S_WAIT_READ);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_off      = r_addr[OffW-1:0];
        w_shamt    = {w_off, 3'b000};
        w_nbytes   = 1 << r_size;
        w_rshift   = master_r_rdata_i >> w_shamt;
        w_addr_inc = r_addr + ({{(BusWidth-1){1'b0}}, 1'b1} << r_size);
        w_be       = '0;
        w_rdata    = '0;
        for (int i = 0; i < NumBytes; i++) begin
            if (i >= int'(w_off) && i < int'(w_off) + w_nbytes) w_be[i] = 1'b1;
            if (i < w_nbytes) w_rdata[8*i +: 8] = w_rshift[8*i +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= '0;
            r_autoinc    <= 1'b0;
            r_cnt        <= '0;
            r_sbdata     <= '0;
            r_sbaddress  <= '0;
            r_data_valid <= 1'b0;
            r_addr_upd   <= 1'b0;
            r_busyerr    <= 1'b0;
            r_err_valid  <= 1'b0;
            r_err        <= '0;
        end else begin
            r_data_valid <= 1'b0;
            r_addr_upd   <= 1'b0;
            r_busyerr    <= 1'b0;
            r_err_valid  <= 1'b0;
            r_err        <= '0;
            if (w_trig) begin
                r_cnt <= '0;
                if (w_size_err) begin
                    r_err_valid <= 1'b1;
                    r_err       <= 3'd4;
                end else if (w_misalign) begin
                    r_err_valid <= 1'b1;
                    r_err       <= 3'd3;
                end else begin
                    r_addr    <= sbaddress_i;
                    r_size    <= sbaccess_i;
                    r_wdata   <= sbdata_i;
                    r_autoinc <= sbautoincrement_i;
                end
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_timeout) begin
                r_err_valid <= 1'b1;
                r_err       <= 3'd1;
            end
            if (w_busy_hit) r_busyerr <= 1'b1;
            if (w_done_rd) begin
                r_sbdata     <= w_rdata;
                r_data_valid <= 1'b1;
            end
            if (w_done) begin
                if (r_autoinc) begin
                    r_sbaddress <= w_addr_inc;
                    r_addr_upd  <= 1'b1;
                end else begin
                    r_sbaddress <= r_addr;
                end
            end
        end
    end

    assign master_add_o    = {r_addr[BusWidth-1:OffW], {OffW{1'b0}}};
    assign master_wdata_o  = r_wdata << w_shamt;
    assign master_be_o     = master_req_o ? w_be : '0;
    assign sbaddress_o     = r_sbaddress;
    assign sbaddress_upd_o = r_addr_upd;
    assign sbdata_o        = r_sbdata;
    assign sbdata_valid_o  = r_data_valid;
    assign sbbusy_o        = (r_state != S_IDLE);
    assign sbbusyerror_o   = r_busyerr;
    assign sberror_valid_o = r_err_valid;
    assign sberror_o       = r_err;

endmodule
